// File: rtl/drive_pkg.sv
// Shared types and motor command codes for the drive arbiter and the decision tree.
package drive_pkg;

  typedef enum logic [1:0] {IDLE, MAN, AUTO, DRAIN} arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_MAN  = 2'b01,
    SRC_AUTO = 2'b10
  } src_t;

  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] CMD_FWD   = 8'h01;
  localparam logic [7:0] CMD_REV   = 8'h02;
  localparam logic [7:0] CMD_LEFT  = 8'h03;
  localparam logic [7:0] CMD_RIGHT = 8'h04;

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating cycle counter that fires a single expire pulse at LIMIT-1 and
// stays disarmed until the next clear.
module cmd_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic         armed_q;
  logic         at_last;

  assign at_last  = (cnt_q == LAST);
  assign expire_o = en_i && !clr_i && armed_q && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (clr_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (en_i) begin
      if (!at_last) cnt_q <= cnt_q + 1'b1;
      if (expire_o) armed_q <= 1'b0;
    end
  end

endmodule

// File: rtl/drive_arbiter.sv
// Single owner of the motor-command channel: manual vs autonomous source with
// forced STOP + hold on every switch. DRIVE_ARB_STATS_EN adds event counters.
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned CMD_W            = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 50_000_000,
  parameter int unsigned STOP_HOLD_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             manual_on,
  input  logic             auto_on,
  input  logic             e_stop,
  input  logic [CMD_W-1:0] man_cmd,
  input  logic             man_valid,
  output logic             man_ready,
  input  logic [CMD_W-1:0] auto_cmd,
  input  logic             auto_valid,
  output logic             auto_ready,
  output logic [CMD_W-1:0] motor_cmd,
  output logic             motor_valid,
  input  logic             motor_ready,
  output logic [1:0]       active_src,
  output logic             timeout_pulse
`ifdef DRIVE_ARB_STATS_EN
  ,
  output logic [15:0]      timeout_count,
  output logic [15:0]      estop_count
`endif
);

  arb_state_t       state_q, state_d, target, tgt_q;
  src_t             src;
  logic [CMD_W-1:0] motor_cmd_q, acc_cmd;
  logic             motor_valid_q, timeout_pulse_q, hold_run_q;
  logic             slot_free, hs, accept, enter_drain, load_stop;
  logic             wd_en, wd_clr, wd_expire;
  logic             hold_en, hold_clr, hold_expire;

  always_comb begin
    if (e_stop)         target = IDLE;
    else if (manual_on) target = MAN;
    else if (auto_on)   target = AUTO;
    else                target = IDLE;
  end

  assign slot_free = !motor_valid_q || motor_ready;
  assign hs        = motor_valid_q && motor_ready;

  always_comb begin
    state_d     = state_q;
    src         = SRC_NONE;
    man_ready   = 1'b0;
    auto_ready  = 1'b0;
    accept      = 1'b0;
    acc_cmd     = man_cmd;
    enter_drain = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      IDLE: if (target != IDLE) begin
        state_d     = DRAIN;
        enter_drain = 1'b1;
      end
      MAN: begin
        src = SRC_MAN;
        if (target != MAN) begin
          state_d     = DRAIN;
          enter_drain = 1'b1;
        end else begin
          man_ready = slot_free;
          accept    = man_valid && slot_free;
          wd_en     = !accept;
        end
      end
      AUTO: begin
        src     = SRC_AUTO;
        acc_cmd = auto_cmd;
        if (target != AUTO) begin
          state_d     = DRAIN;
          enter_drain = 1'b1;
        end else begin
          auto_ready = slot_free;
          accept     = auto_valid && slot_free;
          wd_en      = !accept;
        end
      end
      DRAIN: if (hold_expire) state_d = target;
      default: state_d = IDLE;
    endcase
  end

  // Both a source switch and a watchdog expiry overwrite any unaccepted payload.
  assign load_stop = enter_drain || wd_expire;
  assign wd_clr    = ((state_q != MAN) && (state_q != AUTO)) || accept;

  // Hold only counts once the STOP has been handed to the driver.
  assign hold_en  = hold_run_q && !e_stop;
  assign hold_clr = (state_q != DRAIN) || e_stop || (target != tgt_q);

  cmd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk), .rst_n(rst_n), .clr_i(wd_clr), .en_i(wd_en), .expire_o(wd_expire)
  );

  cmd_watchdog #(.LIMIT(STOP_HOLD_CYCLES)) u_hold (
    .clk(clk), .rst_n(rst_n), .clr_i(hold_clr), .en_i(hold_en), .expire_o(hold_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tgt_q           <= IDLE;
      hold_run_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
      motor_cmd_q     <= CMD_W'(CMD_STOP);
      motor_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgt_q           <= target;
      hold_run_q      <= (state_q == DRAIN) && (hold_run_q || hs);
      timeout_pulse_q <= wd_expire;
      if (load_stop) begin
        motor_cmd_q   <= CMD_W'(CMD_STOP);
        motor_valid_q <= 1'b1;
      end else if (accept) begin
        motor_cmd_q   <= acc_cmd;
        motor_valid_q <= 1'b1;
      end else if (motor_ready) begin
        motor_valid_q <= 1'b0;
      end
    end
  end

  assign motor_cmd     = motor_cmd_q;
  assign motor_valid   = motor_valid_q;
  assign active_src    = src;
  assign timeout_pulse = timeout_pulse_q;

`ifdef DRIVE_ARB_STATS_EN
  logic        e_stop_q;
  logic [15:0] tcnt_q, ecnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_stop_q <= 1'b0;
      tcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      e_stop_q <= e_stop;
      if (wd_expire && (tcnt_q != 16'hFFFF)) tcnt_q <= tcnt_q + 1'b1;
      if (e_stop && !e_stop_q && (ecnt_q != 16'hFFFF)) ecnt_q <= ecnt_q + 1'b1;
    end
  end

  assign timeout_count = tcnt_q;
  assign estop_count   = ecnt_q;
`endif

endmodule
